mem_line_seq: RTL and testbench

//  Cache-line request sequencer between the accelerator core and the word-serial memory controller.

---
 rtl/mem_line_seq_if.sv | 38 +++
 rtl/mem_line_seq.sv | 95 +++++++++
 tb/tb_mem_line_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_seq_if.sv
// Core-side request/response and controller word-protocol signals of the line sequencer.
interface mem_line_seq_if #(
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDR_BITCOUNT-1:0] req_addr;
  logic [CL_SIZE_WIDTH-1:0] req_wdata;
  logic                     rsp_valid;
  logic                     rsp_we;
  logic [CL_SIZE_WIDTH-1:0] rsp_rdata;
  logic                     rsp_err;
  logic                     busy;
  logic                     mc_ready;
  logic [1:0]               mc_op;
  logic [ADDR_BITCOUNT-1:0] mc_addr;
  logic [WORD_SIZE-1:0]     mc_wdata;
  logic [WORD_SIZE-1:0]     mc_rdata;
  logic                     mc_rd_valid;
  logic                     mc_tx_done;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mc_ready, mc_rdata, mc_rd_valid, mc_tx_done,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err, busy,
    output mc_op, mc_addr, mc_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output mc_ready, mc_rdata, mc_rd_valid, mc_tx_done,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err, busy,
    input  mc_op, mc_addr, mc_wdata
  );
endinterface

// File: rtl/mem_line_seq.sv
// Cache-line request sequencer: turns one 512-bit line read/write into the
// memory controller's word-serial protocol and returns a one-cycle completion.
module mem_line_seq #(
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int ADDR_BITCOUNT = 64
) (
  input logic           clk,
  input logic           rst_n,
  mem_line_seq_if.slave bus
);
  localparam int WORDS    = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int CNT_W    = $clog2(WORDS);
  localparam int OFF_BITS = $clog2(CL_SIZE_WIDTH / 8);

  typedef enum logic [2:0] {IDLE, ISSUE, WFILL, WWAIT, RWAIT, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     we_q;
  logic [CL_SIZE_WIDTH-1:0] line_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     accept;
  logic                     last_word;

  assign bus.req_ready = (state_q == IDLE) && bus.mc_ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_we    = we_q;
  assign accept        = bus.req_valid && bus.req_ready;
  assign last_word     = (cnt_q == CNT_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = we_q ? WFILL : RWAIT;
      WFILL:   if (last_word) state_d = WWAIT;
      WWAIT:   if (bus.mc_tx_done) state_d = DONE;
      RWAIT:   if (bus.mc_rd_valid && bus.mc_tx_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The write line is kept as a shift register of not-yet-sent words; word 0 is
  // loaded into mc_wdata at accept so it is already stable when WFILL starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      line_q        <= '0;
      cnt_q         <= '0;
      bus.mc_op     <= 2'b00;
      bus.mc_addr   <= '0;
      bus.mc_wdata  <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          we_q        <= bus.req_we;
          bus.mc_addr <= {bus.req_addr[ADDR_BITCOUNT-1:OFF_BITS], {OFF_BITS{1'b0}}};
          bus.mc_op   <= bus.req_we ? 2'b11 : 2'b01;
          if (bus.req_we) begin
            line_q       <= bus.req_wdata >> WORD_SIZE;
            bus.mc_wdata <= bus.req_wdata[WORD_SIZE-1:0];
          end
        end
        ISSUE: cnt_q <= '0;
        WFILL: if (!last_word) begin
          cnt_q        <= cnt_q + 1'b1;
          bus.mc_wdata <= line_q[WORD_SIZE-1:0];
          line_q       <= line_q >> WORD_SIZE;
        end
        WWAIT: if (bus.mc_tx_done) begin
          bus.mc_op   <= 2'b00;
          bus.rsp_err <= 1'b0;
        end
        RWAIT: if (bus.mc_rd_valid) begin
          bus.rsp_rdata[WORD_SIZE*int'(cnt_q) +: WORD_SIZE] <= bus.mc_rdata;
          if (!last_word) cnt_q <= cnt_q + 1'b1;
          if (bus.mc_tx_done) begin
            bus.mc_op   <= 2'b00;
            bus.rsp_err <= !last_word;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_seq.sv
// Scoreboard bench for mem_line_seq: stimulus pushes expected responses, a
// negedge monitor pops and compares them whenever rsp_valid is seen.
module tb_mem_line_seq;
  localparam int WS    = 32;
  localparam int CL    = 512;
  localparam int AW    = 64;
  localparam int WORDS = 16;

  typedef struct {
    logic          we;
    logic          err;
    logic [CL-1:0] rdata;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mem_line_seq_if #(.WORD_SIZE(WS), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW)) bus();
  mem_line_seq #(.WORD_SIZE(WS), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int            vectors = 0;
  int            miscompares = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [CL-1:0] exp_line = '0;

  task automatic chk(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: rsp_valid got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_cycle", CL'(cyc), CL'(mon_e.cyc));
        chk("rsp_we", CL'(bus.rsp_we), CL'(mon_e.we));
        chk("rsp_err", CL'(bus.rsp_err), CL'(mon_e.err));
        if (!mon_e.we) chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  // Wait (bounded) for acceptance of the currently driven request; t = accept cycle.
  task automatic wait_accept(output int t);
    int waited = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      if (waited >= 50) begin
        chk("accept_timeout", CL'(bus.req_ready), CL'(1));
        break;
      end
      waited++;
    end
    t = cyc;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [CL-1:0] wd,
                       output int t);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    wait_accept(t);
    step();
    bus.req_valid = 1'b0;
  endtask

  function automatic logic [CL-1:0] make_line(input logic [WS-1:0] base);
    logic [CL-1:0] l;
    for (int k = 0; k < WORDS; k++) l[k*WS +: WS] = base + WS'(k);
    return l;
  endfunction

  task automatic write_txn(input logic [AW-1:0] addr, input logic [WS-1:0] base, input bit detailed);
    int t;
    issue(1'b1, addr, make_line(base), t);
    sb.push_back('{we: 1'b1, err: 1'b0, rdata: '0, cyc: t + 20});
    if (detailed) begin
      @(negedge clk);
      chk("wr_issue_op", CL'(bus.mc_op), CL'(2'b11));
      chk("wr_addr", CL'(bus.mc_addr), CL'(addr & ~64'h3F));
      chk("wr_busy", CL'(bus.busy), CL'(1));
      for (int k = 0; k < WORDS; k++) begin
        goto(t + 2 + k);
        @(negedge clk);
        chk("wr_word", CL'(bus.mc_wdata), CL'(base + WS'(k)));
        chk("wr_op_hold", CL'(bus.mc_op), CL'(2'b11));
      end
    end
    goto(t + 19);
    bus.mc_tx_done = 1'b1;
    step();
    bus.mc_tx_done = 1'b0;
    @(negedge clk);
    chk("wr_done_op", CL'(bus.mc_op), CL'(2'b00));
  endtask

  // Controller model: returns nwords words base+k from cycle t+2, with an idle
  // cycle inserted before word k wherever gaps[k] is set.
  task automatic read_words(input int t, input logic [WS-1:0] base, input int nwords,
                            input logic [15:0] gaps);
    goto(t + 2);
    for (int k = 0; k < nwords; k++) begin
      if (gaps[k]) begin
        bus.mc_rd_valid = 1'b0;
        bus.mc_tx_done  = 1'b0;
        step();
      end
      bus.mc_rd_valid = 1'b1;
      bus.mc_rdata    = base + WS'(k);
      bus.mc_tx_done  = (k == nwords - 1);
      exp_line[k*WS +: WS] = base + WS'(k);
      if (k == nwords - 1)
        sb.push_back('{we: 1'b0, err: (nwords != WORDS), rdata: exp_line, cyc: cyc + 1});
      step();
    end
    bus.mc_rd_valid = 1'b0;
    bus.mc_tx_done  = 1'b0;
    bus.mc_rdata    = '0;
    @(negedge clk);
    chk("rd_done_op", CL'(bus.mc_op), CL'(2'b00));
  endtask

  task automatic read_txn(input logic [AW-1:0] addr, input logic [WS-1:0] base, input int nwords,
                          input logic [15:0] gaps);
    int t;
    issue(1'b0, addr, '0, t);
    @(negedge clk);
    chk("rd_issue_op", CL'(bus.mc_op), CL'(2'b01));
    chk("rd_addr", CL'(bus.mc_addr), CL'(addr & ~64'h3F));
    read_words(t, base, nwords, gaps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int d;
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.mc_ready    = 1'b1;
    bus.mc_rdata    = '0;
    bus.mc_rd_valid = 1'b0;
    bus.mc_tx_done  = 1'b0;

    // 1: reset values
    @(negedge clk);
    chk("rst_mc_op", CL'(bus.mc_op), CL'(2'b00));
    chk("rst_mc_addr", CL'(bus.mc_addr), CL'(0));
    chk("rst_mc_wdata", CL'(bus.mc_wdata), CL'(0));
    chk("rst_rsp_valid", CL'(bus.rsp_valid), CL'(0));
    chk("rst_rsp_we", CL'(bus.rsp_we), CL'(0));
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chk("rst_rsp_err", CL'(bus.rsp_err), CL'(0));
    chk("rst_busy", CL'(bus.busy), CL'(0));
    chk("rst_req_ready_mc1", CL'(bus.req_ready), CL'(1));
    bus.mc_ready = 1'b0;
    #1;
    chk("rst_req_ready_mc0", CL'(bus.req_ready), CL'(0));
    bus.mc_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    // 2: full write with word-by-word checks
    write_txn(64'h1047, 32'hA000_0000, 1'b1);

    // 3: read with idle gaps before words 3, 8 and 12
    read_txn(64'h2000, 32'h0000_00B0, WORDS, 16'h1108);

    // 4: short read, tx_done with the 12th word
    read_txn(64'h2040, 32'h0000_00C0, 12, 16'h0000);

    // 5: back-to-back, req_valid held high across write then read
    step();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 64'h4000;
    bus.req_wdata = make_line(32'hE000_0000);
    wait_accept(t);
    sb.push_back('{we: 1'b1, err: 1'b0, rdata: '0, cyc: t + 20});
    step();
    bus.req_we   = 1'b0;
    bus.req_addr = 64'h5000;
    goto(t + 19);
    bus.mc_tx_done = 1'b1;
    step();
    bus.mc_tx_done = 1'b0;
    @(negedge clk);
    chk("b2b_done_op", CL'(bus.mc_op), CL'(2'b00));
    chk("b2b_done_ready", CL'(bus.req_ready), CL'(0));
    step();
    @(negedge clk);
    chk("b2b_idle_ready", CL'(bus.req_ready), CL'(1));
    chk("b2b_idle_op", CL'(bus.mc_op), CL'(2'b00));
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rd_op", CL'(bus.mc_op), CL'(2'b01));
    chk("b2b_rd_addr", CL'(bus.mc_addr), CL'(64'h5000));
    read_words(t + 21, 32'h0000_00D0, WORDS, 16'h0000);

    // 6: reset during WFILL at cnt 7 aborts with no response
    step();
    issue(1'b1, 64'h6000, make_line(32'h5000_0000), t);
    goto(t + 9);
    @(negedge clk);
    chk("abort_pre_word", CL'(bus.mc_wdata), CL'(32'h5000_0007));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_op", CL'(bus.mc_op), CL'(2'b00));
    chk("abort_busy", CL'(bus.busy), CL'(0));
    chk("abort_rsp_valid", CL'(bus.rsp_valid), CL'(0));
    chk("abort_wdata", CL'(bus.mc_wdata), CL'(0));
    exp_line = '0;
    goto(t + 11);
    rst_n = 1'b1;
    goto(t + 30);
    write_txn(64'h7010, 32'h7000_0000, 1'b1);

    d = 0;
    while (sb.size() > 0 && d < 100) begin
      step();
      d++;
    end
    chk("scoreboard_drain", CL'(sb.size()), CL'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
